// File: rtl/serial_rotate_shifter_pkg.sv
// rtl/serial_rotate_shifter_pkg.sv - shared constants and encodings for the serial rotate/arith shifter
package serial_rotate_shifter_pkg;

  localparam int WIDTH = 8;
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    OP_SRA = 2'b00,
    OP_ROR = 2'b01,
    OP_ROL = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SHIFT  = 2'b01,
    ST_FINISH = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - one-bit-position SRA/ROR/ROL selector
module shift_step
  import serial_rotate_shifter_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] data_in,
  input  op_e          op,
  output logic [W-1:0] data_out
);

  always_comb begin
    data_out = data_in;
    case (op)
      OP_SRA:  data_out = {data_in[W-1], data_in[W-1:1]};
      OP_ROR:  data_out = {data_in[0], data_in[W-1:1]};
      OP_ROL:  data_out = {data_in[W-2:0], data_in[W-1]};
      default: data_out = data_in;
    endcase
  end

endmodule

// File: rtl/serial_rotate_shifter.sv
// rtl/serial_rotate_shifter.sv - multi-cycle SRA/ROR/ROL unit with START/BUSY/DONE handshake
module serial_rotate_shifter
  import serial_rotate_shifter_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [1:0]       OP,
  input  logic [WIDTH-1:0] DATA_IN,
  input  logic [7:0]       SHIFT_AMT,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT
);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  reg_q, reg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  op_e               op_q, op_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic [WIDTH-1:0]  step_out;
  logic [CNT_W-1:0]  eff_cnt;
  op_e               op_in;

  assign op_in = op_e'(OP);

  shift_step #(.W(WIDTH)) u_step (
    .data_in  (reg_q),
    .op       (op_q),
    .data_out (step_out)
  );

  // SRA saturates at WIDTH-1 steps: beyond that every bit is already the sign
  always_comb begin
    eff_cnt = '0;
    case (op_in)
      OP_SRA:  eff_cnt = (SHIFT_AMT >= 8'(WIDTH - 1)) ? CNT_W'(WIDTH - 1)
                                                       : SHIFT_AMT[CNT_W-1:0];
      OP_ROR,
      OP_ROL:  eff_cnt = SHIFT_AMT[CNT_W-1:0];
      default: eff_cnt = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    reg_d    = reg_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    result_d = result_q;
    done_d   = 1'b0;
    busy_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_SHIFT;
          reg_d   = DATA_IN;
          op_d    = op_in;
          cnt_d   = eff_cnt;
          busy_d  = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (cnt_q != '0) begin
          reg_d  = step_out;
          cnt_d  = cnt_q - CNT_W'(1);
          busy_d = 1'b1;
        end else begin
          result_d = reg_q;
          done_d   = 1'b1;
          state_d  = ST_FINISH;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      reg_q    <= '0;
      cnt_q    <= '0;
      op_q     <= OP_SRA;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      reg_q    <= reg_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign RESULT = result_q;

endmodule

// File: tb/tb_serial_rotate_shifter.sv
// tb/tb_serial_rotate_shifter.sv - directed self-checking bench for serial_rotate_shifter
module tb_serial_rotate_shifter;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       START = 1'b0;
  logic [1:0] OP = 2'b00;
  logic [7:0] DATA_IN = 8'h00;
  logic [7:0] SHIFT_AMT = 8'h00;
  logic       BUSY;
  logic       DONE;
  logic [7:0] RESULT;

  int pass_cnt = 0;
  int total_cnt = 0;

  serial_rotate_shifter dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .START     (START),
    .OP        (OP),
    .DATA_IN   (DATA_IN),
    .SHIFT_AMT (SHIFT_AMT),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .RESULT    (RESULT)
  );

  always #5 CLK = ~CLK;

  // Leaves the bench at the falling edge after accepting edge k; scrambles inputs unless held
  task automatic launch(input logic [1:0] op, input logic [7:0] din,
                        input logic [7:0] amt, input bit hold);
    @(negedge CLK);
    OP = op; DATA_IN = din; SHIFT_AMT = amt; START = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    if (!hold) begin
      START = 1'b0;
      DATA_IN = ~din;
      OP = op ^ 2'b01;
      SHIFT_AMT = amt + 8'd3;
    end
  endtask

  // edges = number of edges after k at which DONE was first seen, -1 on timeout
  task automatic wait_done(output int edges, output int busy_n);
    edges = -1;
    busy_n = BUSY ? 1 : 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge CLK);
      if (DONE) begin
        edges = i;
        break;
      end
      if (BUSY) busy_n++;
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1; START = 1'b1;
    repeat (3) @(negedge CLK);
    total_cnt++; if (BUSY !== 1'b0) $display("FAIL reset_busy: got %b want 0", BUSY); else pass_cnt++;
    total_cnt++; if (DONE !== 1'b0) $display("FAIL reset_done: got %b want 0", DONE); else pass_cnt++;
    total_cnt++; if (RESULT !== 8'h00) $display("FAIL reset_result: got %h want 00", RESULT); else pass_cnt++;
    START = 1'b0; RESET = 1'b0;
  endtask

  task automatic test_sra();
    int e, b;
    launch(2'b00, 8'h90, 8'd3, 1'b0);
    wait_done(e, b);
    total_cnt++; if (e !== 4) $display("FAIL sra_latency: got %0d want 4", e); else pass_cnt++;
    total_cnt++; if (b !== 4) $display("FAIL sra_busy_cycles: got %0d want 4", b); else pass_cnt++;
    total_cnt++; if (RESULT !== 8'hF2) $display("FAIL sra_result: got %h want F2", RESULT); else pass_cnt++;
    total_cnt++; if (BUSY !== 1'b0) $display("FAIL sra_busy_at_done: got %b want 0", BUSY); else pass_cnt++;
    @(negedge CLK);
    total_cnt++; if (DONE !== 1'b0) $display("FAIL sra_done_pulse: got %b want 0", DONE); else pass_cnt++;
    total_cnt++; if (RESULT !== 8'hF2) $display("FAIL sra_result_hold: got %h want F2", RESULT); else pass_cnt++;
  endtask

  task automatic test_rotate();
    int e, b;
    launch(2'b01, 8'h81, 8'd1, 1'b0);
    wait_done(e, b);
    total_cnt++; if (e !== 2) $display("FAIL ror_latency: got %0d want 2", e); else pass_cnt++;
    total_cnt++; if (RESULT !== 8'hC0) $display("FAIL ror_result: got %h want C0", RESULT); else pass_cnt++;
    launch(2'b10, 8'h81, 8'd9, 1'b0);
    wait_done(e, b);
    total_cnt++; if (e !== 2) $display("FAIL rol_mod_latency: got %0d want 2", e); else pass_cnt++;
    total_cnt++; if (RESULT !== 8'h03) $display("FAIL rol_mod_result: got %h want 03", RESULT); else pass_cnt++;
  endtask

  task automatic test_saturation();
    int e, b;
    launch(2'b00, 8'h40, 8'd200, 1'b0);
    wait_done(e, b);
    total_cnt++; if (e !== 8) $display("FAIL sat_pos_latency: got %0d want 8", e); else pass_cnt++;
    total_cnt++; if (RESULT !== 8'h00) $display("FAIL sat_pos_result: got %h want 00", RESULT); else pass_cnt++;
    launch(2'b00, 8'h80, 8'd8, 1'b0);
    wait_done(e, b);
    total_cnt++; if (e !== 8) $display("FAIL sat_neg_latency: got %0d want 8", e); else pass_cnt++;
    total_cnt++; if (RESULT !== 8'hFF) $display("FAIL sat_neg_result: got %h want FF", RESULT); else pass_cnt++;
  endtask

  task automatic test_zero_reserved();
    int e, b;
    launch(2'b10, 8'h5A, 8'd0, 1'b0);
    wait_done(e, b);
    total_cnt++; if (e !== 1) $display("FAIL zero_latency: got %0d want 1", e); else pass_cnt++;
    total_cnt++; if (b !== 1) $display("FAIL zero_busy_cycles: got %0d want 1", b); else pass_cnt++;
    total_cnt++; if (RESULT !== 8'h5A) $display("FAIL zero_result: got %h want 5A", RESULT); else pass_cnt++;
    launch(2'b11, 8'h5A, 8'd5, 1'b0);
    wait_done(e, b);
    total_cnt++; if (e !== 1) $display("FAIL rsv_latency: got %0d want 1", e); else pass_cnt++;
    total_cnt++; if (RESULT !== 8'h5A) $display("FAIL rsv_result: got %h want 5A", RESULT); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int e, b;
    launch(2'b01, 8'h0F, 8'd4, 1'b1);
    DATA_IN = 8'h3C;
    wait_done(e, b);
    total_cnt++; if (e !== 5) $display("FAIL hold_latency: got %0d want 5", e); else pass_cnt++;
    total_cnt++; if (RESULT !== 8'hF0) $display("FAIL hold_result: got %h want F0", RESULT); else pass_cnt++;
    @(negedge CLK);
    total_cnt++; if (BUSY !== 1'b0) $display("FAIL finish_ignores_start: got %b want 0", BUSY); else pass_cnt++;
    @(negedge CLK);
    total_cnt++; if (BUSY !== 1'b1) $display("FAIL idle_accepts_start: got %b want 1", BUSY); else pass_cnt++;
    START = 1'b0;
    wait_done(e, b);
    total_cnt++; if (e !== 5) $display("FAIL second_latency: got %0d want 5", e); else pass_cnt++;
    total_cnt++; if (RESULT !== 8'hC3) $display("FAIL second_result: got %h want C3", RESULT); else pass_cnt++;
  endtask

  task automatic test_reset_mid_op();
    int e, b;
    int done_seen;
    launch(2'b10, 8'h01, 8'd6, 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    total_cnt++; if (BUSY !== 1'b0) $display("FAIL abort_busy: got %b want 0", BUSY); else pass_cnt++;
    total_cnt++; if (RESULT !== 8'h00) $display("FAIL abort_result: got %h want 00", RESULT); else pass_cnt++;
    RESET = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (DONE) done_seen++;
      @(negedge CLK);
    end
    total_cnt++; if (done_seen !== 0) $display("FAIL abort_no_done: got %0d pulses want 0", done_seen); else pass_cnt++;
    launch(2'b00, 8'h80, 8'd1, 1'b0);
    wait_done(e, b);
    total_cnt++; if (e !== 2) $display("FAIL post_abort_latency: got %0d want 2", e); else pass_cnt++;
    total_cnt++; if (RESULT !== 8'hC0) $display("FAIL post_abort_result: got %h want C0", RESULT); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_sra();
    test_rotate();
    test_saturation();
    test_zero_reserved();
    test_back_to_back();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
